mem_arbiter: RTL

// Arbitrates one single-port, word-addressed backing memory between two requesters:
//  - the I-cache refill path (i_miss burst of LINE_WORDS words);
//  - the MEM-stage load/store path (single-word access).

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port word memory between I-cache line refills and MEM-stage loads/stores.
// Round-robin on ties; bursts are non-interruptible; all memory-side outputs are registered.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          i_miss,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [DATA_W-1:0]             i_word,
    output logic [$clog2(LINE_WORDS)-1:0] i_word_idx,
    output logic                          i_word_ready,
    output logic                          i_line_done,
    input  logic                          d_re,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic [DATA_W-1:0]             d_rdata,
    output logic                          d_done,
    output logic                          d_stall,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StIburst, StDacc} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;   // 1: data side was granted last
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_word_q, i_word_d;
    logic [IDX_W-1:0]    i_word_idx_q, i_word_idx_d;
    logic                i_word_ready_q, i_word_ready_d;
    logic                i_line_done_q, i_line_done_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_done_q, d_done_d;

    logic i_req, d_req, grant_i, grant_d, xfer;
    logic [IDX_W-1:0] cnt_inc;

    // Completion pulses mask their own requester so a late drop cannot re-grant.
    assign i_req   = i_miss & ~i_line_done_q;
    assign d_req   = (d_re | d_we) & ~d_done_q;
    assign grant_i = i_req & (~d_req | last_d_q);
    assign grant_d = d_req & (~i_req | ~last_d_q);
    assign xfer    = mem_req_q & mem_ack;
    assign cnt_inc = cnt_q + IDX_W'(1);

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        cnt_d          = cnt_q;
        base_d         = base_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        i_word_d       = i_word_q;
        i_word_idx_d   = i_word_idx_q;
        i_word_ready_d = 1'b0;
        i_line_done_d  = 1'b0;
        d_rdata_d      = d_rdata_q;
        d_done_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d    = StIburst;
                    last_d_d   = 1'b0;
                    cnt_d      = '0;
                    base_d     = i_addr & ~LINE_MASK;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr & ~LINE_MASK;
                end else if (grant_d) begin
                    state_d     = StDacc;
                    last_d_d    = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end
            end
            StIburst: begin
                if (xfer) begin
                    i_word_d       = mem_rdata;
                    i_word_idx_d   = cnt_q;
                    i_word_ready_d = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        mem_req_d     = 1'b0;
                        i_line_done_d = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_addr_d = base_q | ADDR_W'(cnt_inc);
                    end
                end
            end
            StDacc: begin
                if (xfer) begin
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    state_d   = StIdle;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= StIdle;
            last_d_q       <= 1'b1;
            cnt_q          <= '0;
            base_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            i_word_q       <= '0;
            i_word_idx_q   <= '0;
            i_word_ready_q <= 1'b0;
            i_line_done_q  <= 1'b0;
            d_rdata_q      <= '0;
            d_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            i_word_q       <= i_word_d;
            i_word_idx_q   <= i_word_idx_d;
            i_word_ready_q <= i_word_ready_d;
            i_line_done_q  <= i_line_done_d;
            d_rdata_q      <= d_rdata_d;
            d_done_q       <= d_done_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign i_word       = i_word_q;
    assign i_word_idx   = i_word_idx_q;
    assign i_word_ready = i_word_ready_q;
    assign i_line_done  = i_line_done_q;
    assign d_rdata      = d_rdata_q;
    assign d_done       = d_done_q;
    assign d_stall      = (d_re | d_we) & ~d_done_q;

endmodule
